// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage memory access unit: opcodes, funct codes, FSM states.
package mem_access_unit_pkg;

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpJal     = 6'b000011;
    localparam logic [5:0] OpLb      = 6'b100000;
    localparam logic [5:0] OpLh      = 6'b100001;
    localparam logic [5:0] OpLw      = 6'b100011;
    localparam logic [5:0] OpLbu     = 6'b100100;
    localparam logic [5:0] OpLhu     = 6'b100101;
    localparam logic [5:0] OpSb      = 6'b101000;
    localparam logic [5:0] OpSh      = 6'b101001;
    localparam logic [5:0] OpSw      = 6'b101011;

    localparam logic [5:0] FnJalr = 6'b001001;
    localparam logic [5:0] FnMfhi = 6'b010000;
    localparam logic [5:0] FnMflo = 6'b010010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_load(logic [5:0] op);
        case (op)
            OpLb, OpLh, OpLw, OpLbu, OpLhu: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(logic [5:0] op);
        case (op)
            OpSb, OpSh, OpSw: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // R-type functs that write rd: shifts, jalr, mfhi/mflo and the ALU group.
    function automatic logic rtype_writes_rd(logic [5:0] funct);
        casez (funct)
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: return 1'b1;
            FnJalr, FnMfhi, FnMflo:          return 1'b1;
            6'b100???, 6'b10101?:            return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ext_unit.sv
// Byte-enable and store-lane generation plus load sign/zero extension (little-endian lanes).
module mem_ext_unit
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (op_i)
            OpSh: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            OpSb: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (op_i)
            OpLb:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   rdata_o = {24'b0, byte_sel};
            OpLh:    rdata_o = {{16{half_sel[15]}}, half_sel};
            OpLhu:   rdata_o = {16'b0, half_sel};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: decode, fault check, req/ack FSM with timeout, load extension.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DM_SIZE     = 12288,
    parameter int unsigned CHECK_ALIGN = 1,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic              flush_m,
    input  logic [31:0]       instr_m,
    input  logic [31:0]       addr_m,
    input  logic [31:0]       wdata_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall_m,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              bus_err,
    output logic [4:0]        rf_dst_m,
    output logic [1:0]        tnew_m
);

    localparam int unsigned     CntW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        alo_q, alo_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d, load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              exc_adel_q, exc_adel_d, exc_ades_q, exc_ades_d;
    logic              bus_err_q, bus_err_d;

    logic [5:0]  op, ext_op;
    logic [1:0]  ext_alo;
    logic        op_ld, op_st, fault;
    logic [3:0]  ext_be;
    logic [31:0] ext_wdata, ext_rdata;
    logic        unused_bits;

    assign op          = instr_m[31:26];
    assign op_ld       = is_load(op);
    assign op_st       = is_store(op);
    assign unused_bits = ^{instr_m[25:21], instr_m[10:6]};

    always_comb begin
        fault = 1'b0;
        if (CHECK_ALIGN != 0) begin
            case (op)
                OpLw, OpSw:        fault = (addr_m[1:0] != 2'b00);
                OpLh, OpLhu, OpSh: fault = addr_m[0];
                default:           fault = 1'b0;
            endcase
            if (addr_m >= 32'(DM_SIZE)) fault = 1'b1;
        end
    end

    // In IDLE the live instruction drives the lanes; afterwards the latched op/offset do.
    assign ext_op  = (state_q == StIdle) ? op : op_q;
    assign ext_alo = (state_q == StIdle) ? addr_m[1:0] : alo_q;

    mem_ext_unit u_ext (
        .op_i      (ext_op),
        .addr_lo_i (ext_alo),
        .wdata_i   (wdata_m),
        .rdata_i   (mem_rdata),
        .be_o      (ext_be),
        .wdata_o   (ext_wdata),
        .rdata_o   (ext_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        alo_d        = alo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        exc_adel_d   = 1'b0;
        exc_ades_d   = 1'b0;
        bus_err_d    = 1'b0;
        stall_m      = 1'b0;
        case (state_q)
            StIdle: begin
                if (valid_m && (op_ld || op_st) && !flush_m) begin
                    if (fault) begin
                        exc_adel_d = op_ld;
                        exc_ades_d = op_st;
                    end else begin
                        stall_m     = 1'b1;
                        state_d     = StWait;
                        cnt_d       = '0;
                        op_d        = op;
                        alo_d       = addr_m[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_st;
                        mem_be_d    = ext_be;
                        mem_addr_d  = {addr_m[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = ext_wdata;
                    end
                end
            end
            StWait: begin
                if (flush_m) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    stall_m = 1'b1;
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = StDone;
                        if (is_load(op_q)) begin
                            load_data_d  = ext_rdata;
                            load_valid_d = 1'b1;
                        end
                    end else if ((TIMEOUT != 0) && (cnt_q == CntMax)) begin
                        mem_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= '0;
            alo_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            exc_adel_q   <= 1'b0;
            exc_ades_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            alo_q        <= alo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            exc_adel_q   <= exc_adel_d;
            exc_ades_q   <= exc_ades_d;
            bus_err_q    <= bus_err_d;
        end
    end

    always_comb begin
        rf_dst_m = 5'd0;
        tnew_m   = 2'd0;
        if (valid_m) begin
            case (op)
                OpSpecial: if (rtype_writes_rd(instr_m[5:0])) rf_dst_m = instr_m[15:11];
                OpJal:     rf_dst_m = 5'd31;
                default: begin
                    if (op[5:3] == 3'b001 || op_ld) rf_dst_m = instr_m[20:16];
                end
            endcase
            if (op_ld) tnew_m = 2'd1;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_data  = load_data_q;
    // A flush during DONE suppresses the result the pipeline would otherwise consume.
    assign load_valid = load_valid_q & ~flush_m;
    assign exc_adel   = exc_adel_q;
    assign exc_ades   = exc_ades_q;
    assign bus_err    = bus_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- M-stage data-memory access unit for the 5-stage MIPS pipeline. Replaces the purely combinational M-stage store decode.
- Decodes loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) and checks address alignment and range.
- Drives a multi-cycle req/ack memory port and stalls the pipeline while the access is outstanding.
- Returns byte-enables and sign/zero-extended load data, alongside the M-stage RF destination and Tnew.

Parameters:
- ADDR_W, 32, width of the memory address port (low ADDR_W bits of the ALU result).
- DM_SIZE, 12288, data-memory size in bytes; an address >= DM_SIZE is out of range.
- CHECK_ALIGN, 1, 1 = raise exceptions on misaligned or out-of-range access; 0 = issue the access regardless.
- TIMEOUT, 16, maximum cycles in WAIT before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid_m  in  1  instr_m holds a live instruction
- flush_m  in  1  kill the current M-stage access
- instr_m  in  32  M-stage instruction word
- addr_m  in  32  ALU-computed effective address
- wdata_m  in  32  forwarded rt value
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write request
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  32  read word, valid with mem_ack
- stall_m  out  1  hold M and all earlier stages
- load_data  out  32  extended load result
- load_valid  out  1  load_data valid (DONE cycle)
- exc_adel  out  1  load address error pulse
- exc_ades  out  1  store address error pulse
- bus_err  out  1  timeout pulse
- rf_dst_m  out  5  destination register (0 if none)
- tnew_m  out  2  cycles until the result is available

Behaviour:
- Reset (synchronous, active-high): state IDLE; timeout counter 0.
  - Registered outputs clear to 0: mem_req, mem_we, mem_be, load_data, load_valid, exc_*, bus_err.
  - stall_m = 0.
- Decode from instr_m[31:26]:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101
  - sb 101000, sh 101001, sw 101011
- rf_dst_m:
  - rd for R-type ALU/shift/jalr/mfhi/mflo.
  - 31 for jal.
  - rt for I-type ALU and loads.
  - 0 otherwise.
- tnew_m: 1 for loads, 0 otherwise. Both rf_dst_m and tnew_m are combinational.
- Fault condition (CHECK_ALIGN=1 only):
  - lw/sw with addr[1:0]!=0.
  - lh/lhu/sh with addr[0]!=0.
  - Any memory op with addr >= DM_SIZE.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - valid_m & mem-op & !flush_m & fault → pulse exc_adel (loads) or exc_ades (stores) next cycle; no request; stay IDLE; stall_m=0.
  - valid_m & mem-op & !flush_m & no fault → stall_m=1 combinationally; next cycle enter WAIT with mem_req=1 and mem_we/mem_be/mem_addr/mem_wdata registered.
  - Anything else → stall_m=0.
- Byte enables and store data:
  - sw: be=1111.
  - sh: be = addr[1] ? 1100 : 0011; wdata={2{rt[15:0]}}.
  - sb: be = 0001<<addr[1:0]; wdata={4{rt[7:0]}}.
  - Loads: be=1111, we=0.
- WAIT:
  - stall_m=1 and mem_req held stable until mem_ack.
  - On mem_ack: latch extended load_data, drop mem_req, go DONE.
  - Load extension selects the byte/half by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
  - Counter increments each WAIT cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: drop mem_req, pulse bus_err, go IDLE with stall_m=0.
- DONE:
  - stall_m=0 for exactly one cycle so the pipeline advances; load_valid=1.
  - Then IDLE; the next instruction is seen in IDLE.
- mem_ack outside WAIT is ignored.
- flush_m in WAIT or DONE: drop mem_req, no load_valid, go IDLE. A store already acked stays committed.
- Reset mid-access aborts immediately, same as flush_m.
- Non-memory instructions never stall.

Decomposition:
- Shared package (Head.v): opcode/funct constants for the load/store ops; state encodings IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
- One sub-module, mem_ext_unit: combinational byte-enable/store-lane generation plus load extension from (op, addr[1:0], rdata). The FSM stays in mem_access_unit.

Test Plan:
- sw $t,0x10, rt=0x12345678, ack after 3 cycles:
  - mem_req for 3 cycles, be=1111, mem_addr=0x10, wdata=0x12345678.
  - stall_m=1 for 4 cycles, then 0.
- lb addr=0x13, rdata=0x80FF0000, ack after 1 cycle → load_data=0xFFFFFF80, load_valid in DONE, tnew_m=1.
- lhu addr=0x12, rdata=0x8001ABCD → load_data=0x00008001.
- sh addr=0x11 and lw addr=0x3000, CHECK_ALIGN=1:
  - sh → exc_ades one-cycle pulse.
  - lw → exc_adel pulse.
  - Neither asserts mem_req or stall_m.
- lw with mem_ack never asserted, TIMEOUT=16 → bus_err pulse exactly 16 cycles after mem_req rose; FSM back in IDLE; stall_m=0.
- sb addr=0x22 with flush_m in the second WAIT cycle:
  - be=0100 while pending.
  - mem_req drops the next cycle; no load_valid.
  - A later ack is ignored.
